// File: rtl/pipe_delay_line_pkg.sv
// Shared helpers for the elastic delay line: sizing of the occupancy counter.
package pipe_delay_line_pkg;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_delay_stage.sv
// One register stage of the delay line: payload register plus valid flag.
// Flush beats load, load beats clear.
module pipe_delay_stage #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             v
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      data_d  = RESET_VAL;
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = d;
      valid_d = 1'b1;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q = data_q;
  assign v = valid_q;

endmodule

// File: rtl/pipe_delay_line.sv
// Elastic WIDTH x DEPTH delay line with valid/ready, global stall, flush,
// per-stage taps and a registered occupancy count.
module pipe_delay_line
  import pipe_delay_line_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int OCC_W = occ_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     stall,
  input  logic                     flush,
  output logic [DEPTH-1:0]         tap_valid,
  output logic [WIDTH*DEPTH-1:0]   tap_data,
  output logic [OCC_W-1:0]         occupancy
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic             accept;
  logic [OCC_W-1:0] occ_q, occ_d;

  // Advance chain walks from the output back so each stage sees whether the
  // one ahead of it is empty or leaving; empty stages absorb bubbles.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = valid[DEPTH-1] & out_ready & ~stall;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = valid[i] & (~valid[i+1] | adv[i+1]) & ~stall;
    end
  end

  assign in_ready  = ~rst & ~stall & ~flush & (~valid[0] | adv[0]);
  assign accept    = in_valid & in_ready;
  assign out_valid = valid[DEPTH-1] & ~stall;
  assign out_data  = stage_q[DEPTH-1];
  assign tap_valid = valid;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             load_w;
      logic [WIDTH-1:0] d_w;

      if (gi == 0) begin : g_head
        assign load_w = accept;
        assign d_w    = in_data;
      end else begin : g_body
        assign load_w = adv[gi-1];
        assign d_w    = stage_q[gi-1];
      end

      pipe_delay_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .load  (load_w),
        .clear (adv[gi]),
        .d     (d_w),
        .q     (stage_q[gi]),
        .v     (valid[gi])
      );

      assign tap_data[gi*WIDTH +: WIDTH] = stage_q[gi];
    end
  endgenerate

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(accept) - OCC_W'(adv[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule
